bus_dma_master: RTL and testbench
=================================

// Module: bus_dma_master
// PURPOSE
//  Word-granular memory-to-memory DMA engine with two sides. A CPU-side register target
//  sits on one address-decode slot; a bus initiator drives the picorv32 native memory
//  interface (valid/ready) into the same decode fabric as the CPU, via the top-level arbiter.
//  Copies LEN 32-bit words from SRC to DST; either pointer can be held fixed for peripheral FIFOs.
// PARAMETERS
//  LEN_W   16  width of word-count register; max transfer (2^LEN_W)-1 words
// PORTS
//  clk      in   1      system clock
//  reset    in   1      synchronous, active-high reset
//  cs       in   1      register-target select (decoded slot & CPU mem_valid)
//  we       in   4      CPU write strobes; all 4'b0000 = read
//  addr     in   2      register index (CPU mem_addr[3:2])
//  din      in   32     CPU write data
//  dout     out  32     register read data, combinational from addr
//  rdy      out  1      register-target ready pulse
//  m_valid  out  1      initiator request valid
//  m_addr   out  32     initiator word address, [1:0] always 2'b00
//  m_wdata  out  32     initiator write data
//  m_wstrb  out  4      4'h0 read, 4'hF write
//  m_ready  in   1      responder ready; transaction completes on m_valid & m_ready
//  m_rdata  in   32     responder read data, sampled when m_valid & m_ready
//  irq      out  1      done interrupt (only with DMA_IRQ_EN)
// BEHAVIOUR
//  Registers: 0 SRC, 1 DST, 2 LEN (reads remaining count), 3 CTRL.
//  CTRL bits: [0] START (W, self-clearing); [1] ABORT (W); [2] SRC_FIXED; [3] DST_FIXED;
//             [4] IE; [8] BUSY (RO); [9] DONE (W1C).
//  Register writes take effect on cs & |we & ~rdy. Any we bit writes the whole register.
//  SRC/DST writes force [1:0]=0. SRC/DST/LEN/CTRL[3:2] writes are ignored while BUSY.
//  rdy: registered; rdy <= cs & ~rdy. One pulse per access, one-cycle latency.
//  Reset values: all registers 0; m_valid=0; m_wstrb=0; m_addr=0; m_wdata=0; rdy=0; irq=0.
//  FSM states: IDLE, RD, RGAP, WR, WGAP, FIN.
//   IDLE: START=1 with LEN!=0 -> RD, BUSY=1, DONE cleared.
//         START=1 with LEN==0 -> FIN (no bus traffic).
//         START while BUSY is ignored.
//   RD:   m_valid=1, m_wstrb=0, m_addr=src_ptr. Hold until m_ready.
//         On handshake: buf<=m_rdata -> RGAP.
//   RGAP: m_valid=0 for exactly 1 cycle (responders use pulse-ready) -> WR.
//   WR:   m_valid=1, m_wstrb=4'hF, m_addr=dst_ptr, m_wdata=buf. Hold until m_ready.
//         On handshake: LEN<=LEN-1; src_ptr+=4 unless SRC_FIXED; dst_ptr+=4 unless DST_FIXED
//         -> WGAP.
//   WGAP: m_valid=0 for 1 cycle. LEN==0 or abort pending -> FIN; else -> RD.
//   FIN:  BUSY=0; DONE=1 -> IDLE. FIN lasts 1 cycle.
//  Handshake: while m_valid=1, m_addr/m_wdata/m_wstrb are stable and never withdrawn.
//   m_ready seen while m_valid=0 is ignored.
//  ABORT while BUSY latches an abort-pending flag. The in-flight read+write pair completes;
//   exit is at the next WGAP. LEN then reads the remaining count. ABORT while IDLE is ignored.
//  Pointers wrap modulo 2^32 (0xFFFF_FFFC+4 = 0).
//  SRC/DST registers read the live pointer values during a transfer.
//  DONE set (FIN) and DONE W1C in the same cycle: set wins.
//  Reset during a transfer: next cycle IDLE, m_valid=0, all registers cleared. No completion.
// CONFIGURATION
//  DMA_IRQ_EN defined:
//   irq = DONE & IE, level; cleared by DONE W1C. CTRL[4] is read/write.
//  DMA_IRQ_EN undefined:
//   irq tied 0; CTRL[4] reads 0 and writes are ignored.
// TESTING
//  1 SRC=0x1000_0000 DST=0x1000_0100 LEN=4, START, responder ready 1 cycle after valid
//    -> R/W alternate with 1-cycle gaps; 4 words copied; DONE=1, BUSY=0, LEN=0.
//  2 LEN=0, START -> DONE=1 within 2 cycles; m_valid never asserted.
//  3 SRC=0x3000_0000 SRC_FIXED=1 LEN=3 DST=0x1000_0200
//    -> 3 reads at 0x3000_0000; writes at 0x..200, 0x..204, 0x..208.
//  4 responder stalls m_ready 5 cycles on a write
//    -> m_valid/m_addr/m_wdata/m_wstrb constant for all 5 cycles; exactly one LEN decrement.
//  5 LEN=8, ABORT written during the 3rd read
//    -> 3rd write completes, then FIN; LEN reads 5; DONE=1; no further m_valid.
//  6 reset asserted mid-write; also START written while BUSY
//    -> reset: m_valid=0 next cycle, registers 0. START while BUSY: transfer unaffected.
//  7 DMA_IRQ_EN, IE=1, LEN=1
//    -> irq rises with DONE; W1C DONE drops irq next cycle; undefined build: irq stays 0.

Source files
------------

// File: rtl/bus_dma_master.sv
// bus_dma_master: word-granular memory-to-memory DMA engine.
//
// A CPU-side register target (SRC, DST, LEN, CTRL) sits on one decode slot. A bus initiator
// drives the picorv32 native memory interface (valid/ready) and copies LEN 32-bit words from
// SRC to DST, one read followed by one write per word. Each access is followed by one idle
// gap cycle. Either pointer can be held fixed for peripheral FIFOs.
//
// Optional feature: define DMA_IRQ_EN to enable the done interrupt (irq_o = DONE & IE) and
// the CTRL.IE bit. Without it irq_o is tied low and CTRL.IE reads 0.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cs_i, we_i, addr_i    register access: select, byte strobes (0 = read), register index
//   din_i, dout_o, rdy_o  register write data, read data (combinational), ready pulse
//   m_valid_o, m_addr_o   initiator request valid and word address
//   m_wdata_o, m_wstrb_o  initiator write data and strobes (4'h0 read, 4'hF write)
//   m_ready_i, m_rdata_i  responder ready and read data
//   irq_o                 done interrupt (level)
module bus_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_i,
    input  logic [3:0]  we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] din_i,
    output logic [31:0] dout_o,
    output logic        rdy_o,
    output logic        m_valid_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_rdata_i,
    output logic        irq_o
);

    typedef enum logic [2:0] {StIdle, StRd, StRgap, StWr, StWgap, StFin} state_e;

    state_e           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic             src_fixed_q;
    logic             dst_fixed_q;
    logic             done_q;
    logic             abort_q;
    logic             rdy_q;
    logic             m_valid_q;
    logic [31:0]      m_addr_q;
    logic [31:0]      m_wdata_q;
    logic [3:0]       m_wstrb_q;

    logic busy;
    logic wr_en;
    logic wr_ctrl;
    logic ie;

    assign busy    = (state_q == StRd) || (state_q == StRgap) ||
                     (state_q == StWr) || (state_q == StWgap);
    assign wr_en   = cs_i & (|we_i) & ~rdy_q;
    assign wr_ctrl = wr_en & (addr_i == 2'd3);

`ifdef DMA_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q <= 1'b0;
        end else if (wr_ctrl) begin
            ie_q <= din_i[4];
        end
    end

    assign ie    = ie_q;
    assign irq_o = done_q & ie_q;
`else
    assign ie    = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            len_q       <= '0;
            src_fixed_q <= 1'b0;
            dst_fixed_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            rdy_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 32'd0;
            m_wstrb_q   <= 4'h0;
        end else begin
            rdy_q <= cs_i & ~rdy_q;

            // Configuration is frozen while a transfer runs; the FSM owns the pointers then.
            if (wr_en && !busy) begin
                case (addr_i)
                    2'd0:    src_q <= {din_i[31:2], 2'b00};
                    2'd1:    dst_q <= {din_i[31:2], 2'b00};
                    2'd2:    len_q <= din_i[LEN_W-1:0];
                    default: ;
                endcase
            end

            if (wr_ctrl) begin
                if (din_i[9]) begin
                    done_q <= 1'b0;
                end
                if (!busy) begin
                    src_fixed_q <= din_i[2];
                    dst_fixed_q <= din_i[3];
                end
                if (din_i[1] && busy) begin
                    abort_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (wr_ctrl && din_i[0]) begin
                        done_q <= 1'b0;
                        if (len_q != '0) begin
                            state_q   <= StRd;
                            m_valid_q <= 1'b1;
                            m_wstrb_q <= 4'h0;
                            m_addr_q  <= src_q;
                        end else begin
                            state_q <= StFin;
                        end
                    end
                end
                StRd: begin
                    if (m_ready_i) begin
                        // Write-data register doubles as the word buffer.
                        m_wdata_q <= m_rdata_i;
                        m_valid_q <= 1'b0;
                        state_q   <= StRgap;
                    end
                end
                StRgap: begin
                    m_valid_q <= 1'b1;
                    m_wstrb_q <= 4'hF;
                    m_addr_q  <= dst_q;
                    state_q   <= StWr;
                end
                StWr: begin
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        len_q     <= len_q - LEN_W'(1);
                        if (!src_fixed_q) begin
                            src_q <= src_q + 32'd4;
                        end
                        if (!dst_fixed_q) begin
                            dst_q <= dst_q + 32'd4;
                        end
                        state_q <= StWgap;
                    end
                end
                StWgap: begin
                    if (len_q == '0 || abort_q) begin
                        state_q <= StFin;
                    end else begin
                        m_valid_q <= 1'b1;
                        m_wstrb_q <= 4'h0;
                        m_addr_q  <= src_q;
                        state_q   <= StRd;
                    end
                end
                StFin: begin
                    // Placed after the W1C handling so a coincident clear loses.
                    done_q  <= 1'b1;
                    abort_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        dout_o = 32'd0;
        unique case (addr_i)
            2'd0: dout_o = src_q;
            2'd1: dout_o = dst_q;
            2'd2: dout_o = 32'(len_q);
            2'd3: dout_o = {22'd0, done_q, busy, 3'd0, ie, dst_fixed_q, src_fixed_q, 2'd0};
        endcase
    end

    assign rdy_o     = rdy_q;
    assign m_valid_o = m_valid_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign m_wstrb_o = m_wstrb_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master: a ROM-like responder, an expected-transaction queue built
// from the transfer parameters, and a negedge compare process checking every valid cycle.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        rdy;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        irq;

`ifdef DMA_IRQ_EN
    localparam bit IrqBuild = 1'b1;
`else
    localparam bit IrqBuild = 1'b0;
`endif

    always #5 clk = ~clk;

    bus_dma_master #(.LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_i      (cs),
        .we_i      (we),
        .addr_i    (addr),
        .din_i     (din),
        .dout_o    (dout),
        .rdy_o     (rdy),
        .m_valid_o (m_valid),
        .m_addr_o  (m_addr),
        .m_wdata_o (m_wdata),
        .m_wstrb_o (m_wstrb),
        .m_ready_i (m_ready),
        .m_rdata_i (m_rdata),
        .irq_o     (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } xact_t;

    xact_t       exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          ready_mode = 0;  // 0 random, 1 ready on 2nd valid cycle, 2 stall first write
    bit          stall_done = 1'b0;
    int          vcnt = 0;
    bit          hs_pending = 1'b0;
    bit          have_prev = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_strb;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Responder and bus compare process.
    initial begin : mon
        bit go;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hs_pending = 1'b0;
                have_prev  = 1'b0;
                vcnt       = 0;
                m_ready    = 1'b0;
            end else begin
                if (hs_pending) begin
                    check("gap_after_handshake", {31'd0, m_valid}, 32'd0);
                    hs_pending = 1'b0;
                    have_prev  = 1'b0;
                    vcnt       = 0;
                end
                if (m_valid) begin
                    if (have_prev) begin
                        check("hold_addr", m_addr, prev_addr);
                        check("hold_wstrb", {28'd0, m_wstrb}, {28'd0, prev_strb});
                        check("hold_wdata", m_wdata, prev_wdata);
                    end
                    if (exp_q.size() == 0) begin
                        check("valid_without_expected_xact", {31'd0, m_valid}, 32'd0);
                    end else begin
                        check("bus_addr", m_addr, exp_q[0].addr);
                        check("bus_wstrb", {28'd0, m_wstrb}, {28'd0, exp_q[0].strb});
                        if (exp_q[0].strb == 4'hF) check("bus_wdata", m_wdata, exp_q[0].data);
                    end
                    prev_addr  = m_addr;
                    prev_wdata = m_wdata;
                    prev_strb  = m_wstrb;
                    have_prev  = 1'b1;
                    case (ready_mode)
                        1: go = (vcnt >= 1);
                        2: begin
                            if (m_wstrb == 4'hF && !stall_done) begin
                                go = (vcnt >= 5);
                                if (go) stall_done = 1'b1;
                            end else begin
                                go = 1'b1;
                            end
                        end
                        default: go = ($urandom_range(0, 2) == 0);
                    endcase
                    vcnt++;
                    if (go) begin
                        m_ready    = 1'b1;
                        m_rdata    = rom(m_addr);
                        hs_pending = 1'b1;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        if (m_wstrb == 4'h0) rd_cnt++;
                        else wr_cnt++;
                    end else begin
                        m_ready = 1'b0;
                        m_rdata = $urandom;
                    end
                end else begin
                    have_prev = 1'b0;
                    vcnt      = 0;
                    // Stray ready while idle must be ignored by the initiator.
                    m_ready   = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    m_rdata   = $urandom;
                end
            end
        end
    end

    // All CPU tasks start and end at posedge + 1.
    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        cs   = 1'b1;
        we   = 4'($urandom_range(1, 15));
        addr = a;
        din  = d;
        @(posedge clk); #1;
        check("rdy_write", {31'd0, rdy}, 32'd1);
        cs = 1'b0;
        we = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        cs   = 1'b1;
        we   = 4'h0;
        addr = a;
        @(posedge clk); #1;
        d  = dout;
        cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n,
                        input bit sf, input bit df);
        logic [31:0] ra, wa;
        for (int i = 0; i < n; i++) begin
            ra = sf ? s : s + 32'(4 * i);
            wa = df ? d : d + 32'(4 * i);
            exp_q.push_back('{addr: ra, strb: 4'h0, data: 32'h0});
            exp_q.push_back('{addr: wa, strb: 4'hF, data: rom(ra)});
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cpu_read(2'd3, v);
            if (v[9]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s_done_timeout: DONE still 0, required 1", tag);
        end
    endtask

    task automatic finish_checks(input logic [31:0] s, input logic [31:0] d, input int n_done,
                                 input int remaining, input bit sf, input bit df, input bit ie,
                                 input string tag);
        logic [31:0] v, ctrl_exp;
        ctrl_exp = 32'h200 | (sf ? 32'h4 : 32'h0) | (df ? 32'h8 : 32'h0) |
                   ((IrqBuild && ie) ? 32'h10 : 32'h0);
        cpu_read(2'd0, v);
        check({tag, "_src"}, v, sf ? s : s + 32'(4 * n_done));
        cpu_read(2'd1, v);
        check({tag, "_dst"}, v, df ? d : d + 32'(4 * n_done));
        cpu_read(2'd2, v);
        check({tag, "_len"}, v, 32'(remaining));
        cpu_read(2'd3, v);
        check({tag, "_ctrl"}, v, ctrl_exp);
        check({tag, "_xacts_left"}, 32'(exp_q.size()), 32'(2 * remaining));
        exp_q.delete();
    endtask

    task automatic run_xfer(input logic [31:0] s_raw, input logic [31:0] d_raw,
                            input logic [31:0] lw, input bit sf, input bit df, input bit ie,
                            input bit poke, input string tag);
        logic [31:0] s, d;
        int n;
        s = s_raw & ~32'h3;
        d = d_raw & ~32'h3;
        n = int'(lw[15:0]);
        cpu_write(2'd0, s_raw);
        cpu_write(2'd1, d_raw);
        cpu_write(2'd2, lw);
        plan(s, d, n, sf, df);
        cpu_write(2'd3, {27'd0, ie, df, sf, 2'b01});
        if (poke && n >= 3) begin
            // START and config writes while busy must leave the transfer untouched.
            cpu_write(2'd3, 32'h0000_0001);
            cpu_write(2'd0, 32'hDEAD_BEE0);
            cpu_write(2'd2, 32'h0000_0007);
        end
        wait_done(tag);
        finish_checks(s, d, n, 0, sf, df, ie, tag);
    endtask

    initial begin : wdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] v, s, d, lw;
        bit sf, df, pk, ok;
        int base;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            cpu_read(2'(r), v);
            check("rst_reg", v, 32'd0);
        end

        // 1: basic 4-word copy, responder ready one cycle after valid.
        ready_mode = 1;
        run_xfer(32'h1000_0000, 32'h1000_0100, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, "t1");
        cpu_read(2'd0, v);
        check("t1_src_literal", v, 32'h1000_0010);
        cpu_read(2'd1, v);
        check("t1_dst_literal", v, 32'h1000_0110);

        // 2: W1C clears DONE; LEN=0 start completes without bus traffic.
        cpu_write(2'd3, 32'h0000_0200);
        cpu_read(2'd3, v);
        check("t2_done_w1c", v, 32'h0000_0000);
        cpu_write(2'd2, 32'd0);
        cpu_write(2'd3, 32'h0000_0001);
        cpu_read(2'd3, v);
        check("t2_done_fast", v, 32'h0000_0200);

        // 3: fixed source pointer.
        run_xfer(32'h3000_0000, 32'h1000_0200, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, "t3");
        cpu_read(2'd0, v);
        check("t3_src_literal", v, 32'h3000_0000);
        cpu_read(2'd1, v);
        check("t3_dst_literal", v, 32'h1000_020C);

        // 4: responder stalls the first write for 5 cycles.
        ready_mode = 2;
        stall_done = 1'b0;
        run_xfer(32'h4000_0000, 32'h5000_0000, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, "t4");

        // 5: ABORT during the third read.
        ready_mode = 1;
        s = 32'h2000_0000;
        d = 32'h2000_1000;
        cpu_write(2'd0, s);
        cpu_write(2'd1, d);
        cpu_write(2'd2, 32'd8);
        plan(s, d, 8, 1'b0, 1'b0);
        base = rd_cnt;
        cpu_write(2'd3, 32'h0000_0001);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rd_cnt - base == 2 && m_valid && m_wstrb == 4'h0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL t5_third_read_timeout: third read not seen, required within budget");
        end
        cpu_write(2'd3, 32'h0000_0002);
        wait_done("t5");
        finish_checks(s, d, 3, 5, 1'b0, 1'b0, 1'b0, "t5");
        cpu_read(2'd2, v);
        check("t5_len_literal", v, 32'd5);

        // 6a: reset during a write.
        ready_mode = 0;
        cpu_write(2'd0, 32'h6000_0000);
        cpu_write(2'd1, 32'h7000_0000);
        cpu_write(2'd2, 32'd4);
        plan(32'h6000_0000, 32'h7000_0000, 4, 1'b0, 1'b0);
        cpu_write(2'd3, 32'h0000_0001);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_valid && m_wstrb == 4'hF) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL t6_write_timeout: write not seen, required within budget");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("t6_rst_m_addr", m_addr, 32'd0);
        check("t6_rst_m_wdata", m_wdata, 32'd0);
        check("t6_rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin
            cpu_read(2'(r), v);
            check("t6_rst_reg", v, 32'd0);
        end

        // 6b: START and config writes while busy.
        run_xfer(32'h0800_0000, 32'h0900_0000, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, "t6b");

        // Pointer wrap, fixed destination.
        run_xfer(32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, "wrap");
        run_xfer(32'hFFFF_FFFB, 32'h0000_4000, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, "wrapfix");

        // 7: interrupt.
        run_xfer(32'h0A00_0000, 32'h0B00_0000, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, "t7");
        check("t7_irq_set", {31'd0, irq}, {31'd0, IrqBuild});
        cs   = 1'b1;
        we   = 4'hF;
        addr = 2'd3;
        din  = 32'h0000_0210;
        @(posedge clk); #1;
        check("t7_irq_clear", {31'd0, irq}, 32'd0);
        cs = 1'b0;
        we = 4'h0;
        @(posedge clk); #1;
        cpu_read(2'd3, v);
        check("t7_ctrl_after_w1c", v, IrqBuild ? 32'h10 : 32'h0);
        cpu_write(2'd3, 32'h0000_0000);

        // Randomized transfers.
        ready_mode = 0;
        for (int t = 0; t < 24; t++) begin
            s  = $urandom;
            d  = $urandom;
            if (t % 4 == 0) s = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            lw = {16'($urandom), 16'($urandom_range(0, 6))};
            sf = ($urandom_range(0, 3) == 0);
            df = ($urandom_range(0, 3) == 0);
            pk = ($urandom_range(0, 2) == 0);
            run_xfer(s, d, lw, sf, df, 1'b0, pk, "rand");
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
